// File: rtl/larpix_pkg.sv
// Shared LArPix types and defaults for the event arbitration path.
package larpix_pkg;

    localparam int DEF_WIDTH       = 64;
    localparam int DEF_NUMCHANNELS = 64;

    typedef enum logic [1:0] {
        ARB,
        READ,
        LOAD
    } arb_state_t;

endpackage

// File: rtl/event_arbiter_rr_select.sv
// Round-robin grant search: rotate requests to start after ptr, find first set,
// then rotate the found offset back into a channel index.
module rr_select
    import larpix_pkg::*;
#(
    parameter int N = DEF_NUMCHANNELS,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         grant_valid
);

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W:0]   NUM  = (W + 1)'(N);

    logic [W-1:0] start;
    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    always_comb begin
        start       = (ptr == LAST) ? '0 : ptr + 1'b1;
        rot         = '0;
        off         = '0;
        grant_valid = 1'b0;
        sum         = '0;
        grant       = '0;

        for (int unsigned i = 0; i < N; i++) begin
            int unsigned idx;
            idx = i + int'(start);
            if (idx >= N) idx = idx - N;
            rot[i] = req[idx];
        end

        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !grant_valid) begin
                off         = W'(i);
                grant_valid = 1'b1;
            end
        end

        // Un-rotate modulo N (N need not be a power of two).
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= NUM) sum = sum - NUM;
        grant = sum[W-1:0];
    end

endmodule

// File: rtl/event_arbiter.sv
// Round-robin drain of per-channel local FIFOs into the shared chip FIFO:
// ARB picks a channel, READ pops its head word, LOAD strobes it into the shared FIFO.
module event_arbiter
    import larpix_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUMCHANNELS = DEF_NUMCHANNELS,
    parameter int CHW         = $clog2(NUMCHANNELS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUMCHANNELS-1:0]              local_fifo_empty,
    input  logic [NUMCHANNELS-1:0][WIDTH-2:0]   input_event,
    input  logic [NUMCHANNELS-1:0]              channel_arb_mask,
    input  logic                                fifo_full,
    output logic [NUMCHANNELS-1:0]              read_local_fifo_n,
    output logic [WIDTH-2:0]                    channel_event_out,
    output logic                                load_event,
    output logic [CHW-1:0]                      active_channel,
    output logic                                busy,
    output logic [15:0]                         events_served
);

    localparam logic [NUMCHANNELS-1:0] ONE     = NUMCHANNELS'(1);
    localparam logic [CHW-1:0]         PTR_RST = CHW'(NUMCHANNELS - 1);

    arb_state_t              state_q;
    logic [CHW-1:0]          ptr_q;
    logic [CHW-1:0]          active_q;
    logic [NUMCHANNELS-1:0]  rd_n_q;
    logic [WIDTH-2:0]        evt_q;
    logic                    load_q;
    logic                    busy_q;
    logic [15:0]             events_served_q;

    logic [NUMCHANNELS-1:0]  req_d;
    logic [CHW-1:0]          grant_d;
    logic                    grant_valid_d;

    assign req_d = ~local_fifo_empty & ~channel_arb_mask;

    rr_select #(
        .N (NUMCHANNELS),
        .W (CHW)
    ) u_rr_select (
        .req         (req_d),
        .ptr         (ptr_q),
        .grant       (grant_d),
        .grant_valid (grant_valid_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ARB;
            ptr_q           <= PTR_RST;
            active_q        <= '0;
            rd_n_q          <= '1;
            evt_q           <= '0;
            load_q          <= 1'b0;
            busy_q          <= 1'b0;
            events_served_q <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    load_q <= 1'b0;
                    if (grant_valid_d && !fifo_full) begin
                        active_q <= grant_d;
                        rd_n_q   <= ~(ONE << grant_d);
                        busy_q   <= 1'b1;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    // Head word is still presented this cycle; the pop lands on this edge.
                    rd_n_q  <= '1;
                    evt_q   <= input_event[active_q];
                    ptr_q   <= active_q;
                    load_q  <= 1'b1;
                    state_q <= LOAD;
                end
                LOAD: begin
                    load_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (events_served_q != '1)
                        events_served_q <= events_served_q + 16'd1;
                    state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign read_local_fifo_n = rd_n_q;
    assign channel_event_out = evt_q;
    assign load_event        = load_q;
    assign active_channel    = active_q;
    assign busy              = busy_q;
    assign events_served     = events_served_q;

endmodule

// File: tb/tb_event_arbiter.sv
// Self-checking bench for event_arbiter: FWFT local FIFO models, a transaction-level
// reference compared every cycle, and directed scenarios with literal expectations.
module tb_event_arbiter;

    localparam int N  = 64;
    localparam int EW = 63;

    logic                 clk;
    logic                 reset;
    logic [N-1:0]         local_fifo_empty;
    logic [N-1:0][EW-1:0] input_event;
    logic [N-1:0]         channel_arb_mask;
    logic                 fifo_full;
    logic [N-1:0]         read_local_fifo_n;
    logic [EW-1:0]        channel_event_out;
    logic                 load_event;
    logic [5:0]           active_channel;
    logic                 busy;
    logic [15:0]          events_served;

    event_arbiter #(
        .WIDTH       (64),
        .NUMCHANNELS (N)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .local_fifo_empty  (local_fifo_empty),
        .input_event       (input_event),
        .channel_arb_mask  (channel_arb_mask),
        .fifo_full         (fifo_full),
        .read_local_fifo_n (read_local_fifo_n),
        .channel_event_out (channel_event_out),
        .load_event        (load_event),
        .active_channel    (active_channel),
        .busy              (busy),
        .events_served     (events_served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Local FIFO contents (index 0 is the head word).
    logic [EW-1:0] lf [N][$];

    // Reference model: stage 0 = waiting for a grant, 1 = pop cycle, 2 = load cycle.
    int            m_stage;
    int            m_ptr;
    int            m_ch;
    logic [N-1:0]  exp_rdn;
    logic [EW-1:0] exp_evt;
    logic          exp_load;
    int            exp_act;
    logic          exp_busy;
    int            exp_cnt;

    logic          sn_reset;
    logic          sn_full;
    logic [N-1:0]  sn_req;
    logic [N-1:0]  sn_rdn;

    int            ld_cyc_q [$];
    int            ld_ch_q  [$];
    logic [EW-1:0] ld_evt_q [$];
    int            rd_cyc_q [$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_stage  = 0;
        m_ptr    = N - 1;
        m_ch     = 0;
        exp_rdn  = '1;
        exp_evt  = '0;
        exp_load = 1'b0;
        exp_act  = 0;
        exp_busy = 1'b0;
        exp_cnt  = 0;
    endfunction

    function automatic void model_step();
        bit found;
        if (sn_reset) begin
            model_reset();
            return;
        end
        case (m_stage)
            0: begin
                exp_load = 1'b0;
                found    = 1'b0;
                if (!sn_full) begin
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (sn_req[c] && !found) begin
                            found      = 1'b1;
                            m_ch       = c;
                            exp_act    = c;
                            exp_rdn    = '1;
                            exp_rdn[c] = 1'b0;
                            exp_busy   = 1'b1;
                            m_stage    = 1;
                        end
                    end
                end
            end
            1: begin
                exp_rdn  = '1;
                exp_evt  = (lf[m_ch].size() > 0) ? lf[m_ch][0] : '0;
                m_ptr    = m_ch;
                exp_load = 1'b1;
                m_stage  = 2;
            end
            default: begin
                exp_load = 1'b0;
                exp_busy = 1'b0;
                if (exp_cnt < 65535) exp_cnt++;
                m_stage  = 0;
            end
        endcase
    endfunction

    function automatic void drive_inputs();
        for (int i = 0; i < N; i++) begin
            local_fifo_empty[i] = (lf[i].size() == 0);
            input_event[i]      = (lf[i].size() == 0) ? '1 : lf[i][0];
        end
    endfunction

    function automatic void push(int ch, logic [EW-1:0] v);
        lf[ch].push_back(v);
    endfunction

    function automatic void clear_logs();
        ld_cyc_q.delete();
        ld_ch_q.delete();
        ld_evt_q.delete();
        rd_cyc_q.delete();
    endfunction

    // Compare at the falling edge, then advance model and FIFOs just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        chk("read_local_fifo_n", read_local_fifo_n, exp_rdn);
        chk("channel_event_out", 64'(channel_event_out), 64'(exp_evt));
        chk("load_event", 64'(load_event), 64'(exp_load));
        chk("active_channel", 64'(active_channel), 64'(exp_act));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("events_served", 64'(events_served), 64'(exp_cnt));
        if (read_local_fifo_n !== '1) rd_cyc_q.push_back(cyc);
        if (load_event === 1'b1) begin
            ld_cyc_q.push_back(cyc);
            ld_ch_q.push_back(int'(active_channel));
            ld_evt_q.push_back(channel_event_out);
        end
        sn_reset = reset;
        sn_full  = fifo_full;
        sn_req   = ~local_fifo_empty & ~channel_arb_mask;
        sn_rdn   = read_local_fifo_n;
        @(posedge clk);
        #1;
        model_step();
        if (!sn_reset)
            for (int i = 0; i < N; i++)
                if (!sn_rdn[i] && lf[i].size() > 0) void'(lf[i].pop_front());
        drive_inputs();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic reset_now(string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_rst_rdn"}, read_local_fifo_n, '1);
        chk({tag, "_rst_load"}, 64'(load_event), 64'd0);
        chk({tag, "_rst_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rst_act"}, 64'(active_channel), 64'd0);
        chk({tag, "_rst_evt"}, 64'(channel_event_out), 64'd0);
        chk({tag, "_rst_cnt"}, 64'(events_served), 64'd0);
        model_reset();
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int exp2 [9];

        reset            = 1'b1;
        fifo_full        = 1'b0;
        channel_arb_mask = '0;
        model_reset();
        drive_inputs();
        run(3);
        reset = 1'b0;
        run(2);

        // Single event on channel 5
        clear_logs();
        push(5, 63'h0ABC);
        drive_inputs();
        base = cyc + 1;
        run(6);
        chk("t1_nload", 64'(ld_cyc_q.size()), 64'd1);
        if (ld_cyc_q.size() >= 1 && rd_cyc_q.size() >= 1) begin
            chk("t1_pop_cycle", 64'(rd_cyc_q[0] - base), 64'd1);
            chk("t1_load_cycle", 64'(ld_cyc_q[0] - base), 64'd2);
            chk("t1_channel", 64'(ld_ch_q[0]), 64'd5);
            chk("t1_data", 64'(ld_evt_q[0]), 64'h0ABC);
        end
        chk("t1_served", 64'(events_served), 64'd1);

        // Channels 0, 1, 63 with three events each, fresh from reset
        reset_now("t2");
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            push(0,  63'(64'h100 + k));
            push(1,  63'(64'h110 + k));
            push(63, 63'(64'h1F0 + k));
        end
        drive_inputs();
        run(32);
        exp2 = '{0, 1, 63, 0, 1, 63, 0, 1, 63};
        chk("t2_nload", 64'(ld_cyc_q.size()), 64'd9);
        for (int i = 0; i < ld_ch_q.size() && i < 9; i++)
            chk("t2_order", 64'(ld_ch_q[i]), 64'(exp2[i]));
        for (int i = 1; i < ld_cyc_q.size(); i++)
            chk("t2_spacing", 64'(ld_cyc_q[i] - ld_cyc_q[i-1]), 64'd3);
        if (ld_evt_q.size() >= 3) chk("t2_ch63_first", 64'(ld_evt_q[2]), 64'h1F0);
        chk("t2_served", 64'(events_served), 64'd9);

        // Shared FIFO full stalls arbitration
        clear_logs();
        fifo_full = 1'b1;
        push(2, 63'h2222);
        push(7, 63'h7777);
        drive_inputs();
        run(8);
        chk("t3_no_load", 64'(ld_cyc_q.size()), 64'd0);
        chk("t3_no_pop", 64'(rd_cyc_q.size()), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);
        fifo_full = 1'b0;
        run(10);
        chk("t3_nload", 64'(ld_ch_q.size()), 64'd2);
        if (ld_ch_q.size() >= 2) begin
            chk("t3_first", 64'(ld_ch_q[0]), 64'd2);
            chk("t3_second", 64'(ld_ch_q[1]), 64'd7);
        end

        // Masked channel skipped until unmasked
        clear_logs();
        channel_arb_mask[2] = 1'b1;
        push(2, 63'h2002);
        push(3, 63'h3003);
        drive_inputs();
        run(10);
        chk("t4_masked_nload", 64'(ld_ch_q.size()), 64'd1);
        if (ld_ch_q.size() >= 1) chk("t4_masked_ch", 64'(ld_ch_q[0]), 64'd3);
        channel_arb_mask[2] = 1'b0;
        run(6);
        chk("t4_nload", 64'(ld_ch_q.size()), 64'd2);
        if (ld_ch_q.size() >= 2) chk("t4_unmasked_ch", 64'(ld_ch_q[1]), 64'd2);

        // Reset while in READ: nothing loaded, channel 0 regains priority
        clear_logs();
        push(9, 63'h9009);
        push(0, 63'h0000_1234);
        drive_inputs();
        cycle();
        chk("t5_in_read", 64'(read_local_fifo_n[9]), 64'd0);
        reset_now("t5");
        chk("t5_no_load", 64'(ld_cyc_q.size()), 64'd0);
        run(10);
        chk("t5_nload", 64'(ld_ch_q.size()), 64'd2);
        if (ld_ch_q.size() >= 2) begin
            chk("t5_first", 64'(ld_ch_q[0]), 64'd0);
            chk("t5_second", 64'(ld_ch_q[1]), 64'd9);
        end

        // Counter saturation
        force dut.events_served_q = 16'hFFFE;
        exp_cnt = 16'hFFFE;
        cycle();
        release dut.events_served_q;
        push(4, 63'h4);
        push(5, 63'h5);
        push(6, 63'h6);
        drive_inputs();
        run(14);
        chk("t6_saturated", 64'(events_served), 64'hFFFF);

        // Randomized traffic against the reference model
        reset_now("rnd");
        for (int i = 0; i < 2000; i++) begin
            int ch;
            if ($urandom_range(0, 99) < 45) begin
                ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1))
                                                 : int'($urandom_range(0, 7)) * 9;
                if (lf[ch].size() < 4) push(ch, {$urandom, $urandom});
            end
            if ($urandom_range(0, 99) < 5) begin
                channel_arb_mask = '0;
                for (int k = 0; k < 3; k++) channel_arb_mask[$urandom_range(0, N - 1)] = 1'b1;
            end
            fifo_full = ($urandom_range(0, 99) < 20);
            drive_inputs();
            cycle();
        end
        fifo_full        = 1'b0;
        channel_arb_mask = '0;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
